pool_writeback: RTL and testbench
=================================

POOL_WRITEBACK -- requirements
Module: pool_writeback

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 The block SHALL have a parameter ADDR_W, default 16, giving the write-address width.
REQ-003 The block SHALL have a parameter FIFO_DEPTH, default 4 (power of 2), giving the number of 256-bit words buffered.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: one-cycle pulse that begins a pass.
REQ-007 Port layer1, input, 1: sampled at start; 1 = 256-bit beats, 0 = 128-bit beats.
REQ-008 Port base_addr, input, ADDR_W: first write address, sampled at start.
REQ-009 Port in_data, input, 256: pool-stage result of 32 or 16 signed int8 lanes; lane i is at [8i+7:8i].
REQ-010 Port in_valid, input, 1: in_data is valid this cycle; there is no backpressure.
REQ-011 Port in_end, input, 1: one-cycle pulse marking the end of the pool stream.
REQ-012 Port wr_valid, output, 1: wr_addr and wr_data are valid.
REQ-013 Port wr_ready, input, 1: the memory accepts the word; a transfer occurs when wr_valid and wr_ready are both high.
REQ-014 Port wr_addr, output, ADDR_W: feature-map buffer word address.
REQ-015 Port wr_data, output, 256: packed word.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.
REQ-017 Port done, output, 1: one-cycle completion pulse.
REQ-018 Port overflow, output, 1: sticky flag set when an input beat is dropped.
REQ-019 Port word_cnt, output, ADDR_W: number of words transferred in the current pass.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-021 In IDLE, a start pulse SHALL latch layer1 and base_addr, clear word_cnt, overflow and the packer, and move to RUN.
REQ-022 A start pulse outside IDLE SHALL be ignored.
REQ-023 In IDLE, in_valid and in_end SHALL be ignored.
REQ-024 In RUN with layer1=1, each in_valid beat SHALL push in_data[255:0] into the FIFO as one word.
REQ-025 In RUN with layer1=0, the first in_valid beat SHALL place in_data[127:0] in the low half of the packer; the second beat SHALL fill the high half and push the whole word.
REQ-026 When in_end arrives with the packer half-filled, the half word SHALL be pushed with its high half zero-filled.
REQ-027 When in_valid and in_end occur in the same cycle, the beat SHALL be accepted first and then the end processed, including any flush.
REQ-028 A push when the FIFO is full and no pop occurs that cycle SHALL drop the word and set overflow.
REQ-029 A push when the FIFO is full and a pop occurs in the same cycle SHALL be accepted.
REQ-030 Overflow SHALL stay set until the next accepted start or reset.
REQ-031 wr_valid SHALL equal FIFO not-empty and SHALL be a registered output.
REQ-032 wr_data and wr_addr SHALL hold stable while wr_valid is high and wr_ready is low.
REQ-033 The earliest wr_valid SHALL be the cycle after the push.
REQ-034 Each transfer SHALL increment wr_addr and word_cnt by 1, wrapping modulo 2^ADDR_W.
REQ-035 The first transfer of a pass SHALL use wr_addr = latched base_addr.
REQ-036 in_end in RUN SHALL move the FSM to DRAIN.
REQ-037 DRAIN SHALL go to DONE when the FIFO is empty and no transfer is pending.
REQ-038 DONE SHALL last exactly one cycle, assert done, and return to IDLE.
REQ-039 In DRAIN, in_valid SHALL be ignored.

Reset
REQ-040 When rst_n is low, the FSM SHALL enter IDLE and the FIFO pointers, packer, wr_addr and word_cnt SHALL be 0.
REQ-041 During reset, wr_valid, busy, done and overflow SHALL be 0.
REQ-042 A reset in the middle of a pass SHALL discard all buffered data, with no write occurring after reset deasserts.

Structure
REQ-043 A shared package SHALL hold the FSM state enum, LANE_W=8, WORD_W=256 and HALF_W=128.
REQ-044 The FIFO SHALL be a separate sub-module, wb_fifo, parameterised by depth and width and providing full and empty flags.

Verification
REQ-045 Scenario: layer1=1, base_addr=0x0100, 3 beats, wr_ready=1 -> writes to 0x0100..0x0102 with data equal to the input, word_cnt=3, done one cycle after the last transfer.
REQ-046 Scenario: layer1=0, 3 beats A,B,C, then in_end -> words {B,A} at base and {0,C} at base+1, done pulse.
REQ-047 Scenario: layer1=1, wr_ready=0, 6 back-to-back beats -> first 4 stored, overflow=1, and 4 writes after wr_ready rises.
REQ-048 Scenario: base_addr=0xFFFF, 2 words -> addresses 0xFFFF then 0x0000.
REQ-049 Scenario: rst_n asserted while 2 words are buffered -> wr_valid=0 immediately, busy=0, and no writes after release.
REQ-050 Scenario: start pulsed during RUN, and in_valid coinciding with in_end -> the start is ignored and the final beat is written.

Source files
------------

// File: rtl/pool_writeback_pkg.sv
// Shared types and widths for the pool write-back path.
package pool_writeback_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = 256;
  localparam int unsigned HALF_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for packed write-back words.
// Ports: clr_i synchronous flush, push_i/din_i write side, pop_i/dout_o read
// side, full_o/empty_o flags, last_o when exactly one word is held.
// A push while full is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two, at least 2.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nempty_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign last_o  = (cnt_q == CNT_W'(1));
  assign empty_o = !nempty_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      nempty_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      nempty_q <= (cnt_d != '0);
    end
  end

  // Storage needs no reset: nothing is readable until pushed.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/pool_writeback.sv
// Packs pool-stage results into 256-bit words and writes them to the
// feature-map buffer at consecutive addresses.
// Ports: start/layer1/base_addr begin a pass; in_data/in_valid/in_end carry
// the pool stream (no backpressure); wr_valid/wr_ready/wr_addr/wr_data form
// the write handshake; busy, done, overflow and word_cnt report status.
module pool_writeback
  import pool_writeback_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              layer1,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_end,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_cnt
);

  state_e              state_q, state_d;
  logic                layer1_q, layer1_d;
  logic                half_q, half_d;
  logic [HALF_W-1:0]   low_q, low_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clr_c, push_c, pop_c;
  logic [WORD_W-1:0]   push_data_c;
  logic                fifo_full, fifo_empty, fifo_last;

  assign wr_valid = !fifo_empty;
  assign pop_c    = wr_valid && wr_ready;
  assign wr_addr  = wr_addr_q;
  assign word_cnt = word_cnt_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_c),
    .push_i  (push_c),
    .din_i   (push_data_c),
    .pop_i   (pop_c),
    .dout_o  (wr_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  // Next-state, packer and counters.
  always_comb begin
    state_d     = state_q;
    layer1_d    = layer1_q;
    half_d      = half_q;
    low_d       = low_q;
    wr_addr_d   = wr_addr_q;
    word_cnt_d  = word_cnt_q;
    ovf_d       = ovf_q;
    clr_c       = 1'b0;
    push_c      = 1'b0;
    push_data_c = '0;

    if (pop_c) begin
      wr_addr_d  = wr_addr_q + ADDR_W'(1);
      word_cnt_d = word_cnt_q + ADDR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          layer1_d   = layer1;
          wr_addr_d  = base_addr;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
          half_d     = 1'b0;
          low_d      = '0;
          clr_c      = 1'b1;
        end
      end
      RUN: begin
        // At most one push per cycle: a beat and an end together either
        // complete a word or flush a lone half, never both.
        if (layer1_q) begin
          if (in_valid) begin
            push_c      = 1'b1;
            push_data_c = in_data;
          end
        end else if (in_valid && half_q) begin
          push_c      = 1'b1;
          push_data_c = {in_data[HALF_W-1:0], low_q};
          half_d      = 1'b0;
        end else if (in_valid) begin
          if (in_end) begin
            push_c      = 1'b1;
            push_data_c = {HALF_W'(0), in_data[HALF_W-1:0]};
          end else begin
            low_d  = in_data[HALF_W-1:0];
            half_d = 1'b1;
          end
        end else if (in_end && half_q) begin
          push_c      = 1'b1;
          push_data_c = {HALF_W'(0), low_q};
          half_d      = 1'b0;
        end
        if (in_end) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once the final word is handed off this cycle.
        if (fifo_empty || (fifo_last && pop_c)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push_c && fifo_full && !pop_c) ovf_d = 1'b1;

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      layer1_q   <= 1'b0;
      half_q     <= 1'b0;
      low_q      <= '0;
      wr_addr_q  <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer1_q   <= layer1_d;
      half_q     <= half_d;
      low_q      <= low_d;
      wr_addr_q  <= wr_addr_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_pool_writeback.sv
// Directed self-checking bench for pool_writeback.
module tb_pool_writeback;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         layer1;
  logic [15:0]  base_addr;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_end;
  logic         wr_valid;
  logic         wr_ready;
  logic [15:0]  wr_addr;
  logic [255:0] wr_data;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [15:0]  word_cnt;

  int errors = 0;
  int checks = 0;

  pool_writeback #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer1    (layer1),
    .base_addr (base_addr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_end    (in_end),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer and done logger, sampled on the active edge.
  int           cyc = 0;
  int           xfer_n = 0;
  int           done_n = 0;
  int           done_cyc = 0;
  logic [15:0]  log_addr [64];
  logic [255:0] log_data [64];
  int           log_cyc  [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_valid && wr_ready) begin
      log_addr[6'(xfer_n)] <= wr_addr;
      log_data[6'(xfer_n)] <= wr_data;
      log_cyc[6'(xfer_n)]  <= cyc;
      xfer_n <= xfer_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  // Lane i of pattern k holds k*32+i.
  function automatic logic [255:0] pat(input int unsigned k);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(k * 32 + 32'(i));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic l1, input logic [15:0] base);
    start = 1'b1; layer1 = l1; base_addr = base;
    tick();
    start = 1'b0; layer1 = 1'b0; base_addr = '0;
  endtask

  task automatic beat(input logic v, input logic [255:0] d, input logic e);
    in_valid = v; in_data = d; in_end = e;
    tick();
    in_valid = 1'b0; in_data = '0; in_end = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 60 && done_n == d0; i++) tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({wr_valid, busy, done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {wr_valid, busy, done, overflow});
    end
    checks++;
    if (wr_addr !== 16'h0 || word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts: addr=%h cnt=%h want 0", wr_addr, word_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_layer1();
    int x0 = xfer_n;
    int d0 = done_n;
    do_start(1'b1, 16'h0100);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL l1_busy: got %b want 1", busy); end
    beat(1'b1, pat(1), 1'b0);
    beat(1'b1, pat(2), 1'b0);
    beat(1'b1, pat(3), 1'b1);
    wait_done(d0);
    checks++;
    if (xfer_n - x0 !== 3) begin errors++; $display("FAIL l1_count: got %0d want 3", xfer_n - x0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_addr[6'(x0 + i)] !== 16'(16'h0100 + i) || log_data[6'(x0 + i)] !== pat(32'(i + 1))) begin
        errors++;
        $display("FAIL l1_word%0d: addr=%h want %h", i, log_addr[6'(x0 + i)], 16'(16'h0100 + i));
      end
    end
    checks++;
    if (word_cnt !== 16'd3) begin errors++; $display("FAIL l1_word_cnt: got %0d want 3", word_cnt); end
    checks++;
    if (done_n - d0 !== 1 || done_cyc !== log_cyc[6'(x0 + 2)] + 1) begin
      errors++;
      $display("FAIL l1_done: pulses=%0d at %0d want 1 at %0d", done_n - d0, done_cyc, log_cyc[6'(x0 + 2)] + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL l1_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_layer0();
    int x0 = xfer_n;
    int d0 = done_n;
    logic [255:0] a, b, c, w0, w1;
    a = pat(4); b = pat(5); c = pat(6);
    w0 = {b[127:0], a[127:0]};
    w1 = {128'h0, c[127:0]};
    do_start(1'b0, 16'h0200);
    beat(1'b1, a, 1'b0);
    beat(1'b1, b, 1'b0);
    beat(1'b1, c, 1'b0);
    beat(1'b0, '0, 1'b1);
    wait_done(d0);
    checks++;
    if (xfer_n - x0 !== 2) begin errors++; $display("FAIL l0_count: got %0d want 2", xfer_n - x0); end
    checks++;
    if (log_addr[6'(x0)] !== 16'h0200 || log_data[6'(x0)] !== w0) begin
      errors++;
      $display("FAIL l0_word0: addr=%h data=%h", log_addr[6'(x0)], log_data[6'(x0)]);
    end
    checks++;
    if (log_addr[6'(x0 + 1)] !== 16'h0201 || log_data[6'(x0 + 1)] !== w1) begin
      errors++;
      $display("FAIL l0_word1_flush: addr=%h data=%h", log_addr[6'(x0 + 1)], log_data[6'(x0 + 1)]);
    end
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL l0_done: got %0d want 1", done_n - d0); end
  endtask

  task automatic test_overflow();
    int x0 = xfer_n;
    int d0 = done_n;
    wr_ready = 1'b0;
    do_start(1'b1, 16'h0300);
    for (int i = 0; i < 6; i++) beat(1'b1, pat(32'(10 + i)), 1'b0);
    checks++;
    if (overflow !== 1'b1 || wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: overflow=%b wr_valid=%b want 1 1", overflow, wr_valid);
    end
    checks++;
    if (wr_addr !== 16'h0300 || wr_data !== pat(10)) begin
      errors++;
      $display("FAIL ovf_hold: addr=%h want 0300", wr_addr);
    end
    beat(1'b0, '0, 1'b1);
    wr_ready = 1'b1;
    wait_done(d0);
    checks++;
    if (xfer_n - x0 !== 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", xfer_n - x0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[6'(x0 + i)] !== 16'(16'h0300 + i) || log_data[6'(x0 + i)] !== pat(32'(10 + i))) begin
        errors++;
        $display("FAIL ovf_word%0d: addr=%h want %h", i, log_addr[6'(x0 + i)], 16'(16'h0300 + i));
      end
    end
    checks++;
    if (overflow !== 1'b1 || word_cnt !== 16'd4) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b cnt=%0d want 1 4", overflow, word_cnt);
    end
  endtask

  task automatic test_wrap();
    int x0 = xfer_n;
    int d0 = done_n;
    do_start(1'b1, 16'hFFFF);
    checks++;
    if (overflow !== 1'b0 || word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL start_clear: overflow=%b cnt=%0d want 0 0", overflow, word_cnt);
    end
    beat(1'b1, pat(20), 1'b0);
    beat(1'b1, pat(21), 1'b1);
    wait_done(d0);
    checks++;
    if (xfer_n - x0 !== 2 || log_addr[6'(x0)] !== 16'hFFFF || log_addr[6'(x0 + 1)] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: n=%0d a0=%h a1=%h want 2 ffff 0000", xfer_n - x0, log_addr[6'(x0)], log_addr[6'(x0 + 1)]);
    end
  endtask

  task automatic test_idle_ignore();
    int x0 = xfer_n;
    int d0 = done_n;
    beat(1'b1, pat(30), 1'b0);
    beat(1'b1, pat(31), 1'b1);
    tick();
    tick();
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || xfer_n !== x0 || done_n !== d0) begin
      errors++;
      $display("FAIL idle_ignore: wr_valid=%b busy=%b writes=%0d", wr_valid, busy, xfer_n - x0);
    end
  endtask

  task automatic test_reset_mid();
    int x0 = xfer_n;
    wr_ready = 1'b0;
    do_start(1'b1, 16'h0500);
    beat(1'b1, pat(40), 1'b0);
    beat(1'b1, pat(41), 1'b0);
    checks++;
    if (wr_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: wr_valid=%b want 1", wr_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_now: wr_valid=%b busy=%b addr=%h want 0 0 0", wr_valid, busy, wr_addr);
    end
    tick();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (xfer_n !== x0 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: writes=%0d wr_valid=%b want 0 0", xfer_n - x0, wr_valid);
    end
  endtask

  task automatic test_back_to_back();
    int x0 = xfer_n;
    int d0 = done_n;
    do_start(1'b1, 16'h0400);
    beat(1'b1, pat(50), 1'b0);
    // Stray start mid-run with different settings must have no effect.
    start = 1'b1; layer1 = 1'b0; base_addr = 16'h0999;
    beat(1'b1, pat(51), 1'b0);
    start = 1'b0; layer1 = 1'b0; base_addr = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    beat(1'b1, pat(52), 1'b1);
    wait_done(d0);
    checks++;
    if (xfer_n - x0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", xfer_n - x0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_addr[6'(x0 + i)] !== 16'(16'h0400 + i) || log_data[6'(x0 + i)] !== pat(32'(50 + i))) begin
        errors++;
        $display("FAIL b2b_word%0d: addr=%h want %h", i, log_addr[6'(x0 + i)], 16'(16'h0400 + i));
      end
    end
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", done_n - d0); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; layer1 = 1'b0; base_addr = '0;
    in_data = '0; in_valid = 1'b0; in_end = 1'b0; wr_ready = 1'b1;
    test_reset();
    test_layer1();
    test_layer0();
    test_overflow();
    test_wrap();
    test_idle_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
